// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types, counter encodings and training helper for fetch PC gen
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] SNT      = 2'b00;
    localparam logic [1:0] WNT      = 2'b01;
    localparam logic [1:0] WT       = 2'b10;
    localparam logic [1:0] ST       = 2'b11;
    localparam logic [1:0] CNT_INIT = WNT;

    // Saturating 2-bit counter step toward the resolved direction
    function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == ST) ? ST : cnt + 2'd1;
        else
            return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pht_table.sv
// ============================================================================
// Module : pht_table
// Brief  : Direct-mapped 2-bit counter / target table, async read, trained write
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pht_table
    import fetch_pkg::*;
#(
    parameter int IW = 5,
    parameter int PC = 32
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [IW-1:0] rd_index_in,
    output logic          rd_taken_out,
    output logic [PC-1:0] rd_target_out,
    input  logic          wr_en_in,
    input  logic [IW-1:0] wr_index_in,
    input  logic          wr_taken_in,
    input  logic [PC-1:0] wr_target_in
);

    localparam int DEPTH = 1 << IW;

    logic [1:0]    r_cnt [DEPTH];
    logic [PC-1:0] r_tgt [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= CNT_INIT;
                r_tgt[i] <= '0;
            end
        end else if (wr_en_in) begin
            r_cnt[wr_index_in] <= cnt_train(r_cnt[wr_index_in], wr_taken_in);
            if (wr_taken_in)
                r_tgt[wr_index_in] <= wr_target_in;
        end
    end

    // Read returns the pre-write contents on a same-cycle index collision
    assign rd_taken_out  = r_cnt[rd_index_in][1];
    assign rd_target_out = r_tgt[rd_index_in];

endmodule

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module : fetch_pc_gen
// Brief  : Fetch-stage next-PC generator with BHT-qualified 2-bit prediction
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int            TAG      = 27,
    parameter int            PC       = 32,
    parameter logic [PC-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    output logic              pc_valid_out,
    input  logic              pc_ready_in,
    output logic [PC-1:0]     pc_out,
    output logic              pred_taken_out,
    output logic [PC-TAG-1:0] fetch_index_out,
    output logic [TAG-1:0]    fetch_tag_out,
    input  logic              fetch_hit_in,
    input  logic              update_in,
    input  logic [PC-TAG-1:0] update_index_in,
    input  logic              update_taken_in,
    input  logic [PC-1:0]     update_target_in,
    input  logic              redirect_in,
    input  logic [PC-1:0]     redirect_pc_in,
    input  logic              halt_in
);

    localparam int IW = PC - TAG;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [PC-1:0] r_pc;
    logic [PC-1:0] w_pc_pred;
    logic [PC-1:0] w_tbl_target;
    logic          w_tbl_taken;
    logic          w_valid;
    logic          w_pred_taken;

    pht_table #(
        .IW (IW),
        .PC (PC)
    ) u_pht (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rd_index_in   (r_pc[IW-1:0]),
        .rd_taken_out  (w_tbl_taken),
        .rd_target_out (w_tbl_target),
        .wr_en_in      (update_in),
        .wr_index_in   (update_index_in),
        .wr_taken_in   (update_taken_in),
        .wr_target_in  (update_target_in)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_state <= BOOT;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_in) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                BOOT:    w_state_next = RUN;
                RUN:     w_state_next = halt_in ? HALT : RUN;
                HALT:    w_state_next = HALT;
                default: w_state_next = BOOT;
            endcase
        end
    end

    always_comb begin
        w_valid = (r_state == RUN);
    end

    assign w_pred_taken = w_valid & fetch_hit_in & w_tbl_taken;
    assign w_pc_pred    = w_pred_taken ? w_tbl_target : r_pc + PC'(4);

    // BOOT/HALT hold naturally because w_valid is low outside RUN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_pc <= RESET_PC;
        else if (redirect_in)
            r_pc <= redirect_pc_in;
        else if (w_valid && pc_ready_in)
            r_pc <= w_pc_pred;
    end

    assign pc_valid_out    = w_valid;
    assign pc_out          = r_pc;
    assign pred_taken_out  = w_pred_taken;
    assign fetch_index_out = r_pc[IW-1:0];
    assign fetch_tag_out   = r_pc[PC-1:IW];

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
// Module : tb_fetch_pc_gen
// Brief  : Directed and randomized self-checking bench for fetch_pc_gen
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

    localparam int TAG   = 27;
    localparam int PC    = 32;
    localparam int IW    = PC - TAG;
    localparam int DEPTH = 1 << IW;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          pc_valid_out;
    logic          pc_ready_in;
    logic [PC-1:0] pc_out;
    logic          pred_taken_out;
    logic [IW-1:0] fetch_index_out;
    logic [TAG-1:0] fetch_tag_out;
    logic          fetch_hit_in;
    logic          update_in;
    logic [IW-1:0] update_index_in;
    logic          update_taken_in;
    logic [PC-1:0] update_target_in;
    logic          redirect_in;
    logic [PC-1:0] redirect_pc_in;
    logic          halt_in;

    always #5 clk_in = ~clk_in;

    fetch_pc_gen #(
        .TAG      (TAG),
        .PC       (PC),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .pc_valid_out     (pc_valid_out),
        .pc_ready_in      (pc_ready_in),
        .pc_out           (pc_out),
        .pred_taken_out   (pred_taken_out),
        .fetch_index_out  (fetch_index_out),
        .fetch_tag_out    (fetch_tag_out),
        .fetch_hit_in     (fetch_hit_in),
        .update_in        (update_in),
        .update_index_in  (update_index_in),
        .update_taken_in  (update_taken_in),
        .update_target_in (update_target_in),
        .redirect_in      (redirect_in),
        .redirect_pc_in   (redirect_pc_in),
        .halt_in          (halt_in)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counters as plain integers 0..3, taken when >= 2
    int          m_cnt [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_cnt[i] = 1;
            m_tgt[i] = 32'h0;
        end
        m_pc   = 32'h0;
        m_boot = 1'b1;
        m_halt = 1'b0;
    endfunction

    function automatic bit m_valid();
        return !m_boot && !m_halt;
    endfunction

    function automatic bit m_pred();
        return m_valid() && fetch_hit_in && (m_cnt[m_pc[IW-1:0]] >= 2);
    endfunction

    function automatic void model_step();
        logic [31:0] nxt;
        int          idx;
        nxt = m_pred() ? m_tgt[m_pc[IW-1:0]] : m_pc + 32'd4;
        if (redirect_in) begin
            m_pc   = redirect_pc_in;
            m_boot = 1'b0;
            m_halt = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt) begin
            if (pc_ready_in) m_pc = nxt;
            if (halt_in)     m_halt = 1'b1;
        end
        if (update_in) begin
            idx = int'(update_index_in);
            if (update_taken_in) begin
                m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
                m_tgt[idx] = update_target_in;
            end else begin
                m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("pc_out", pc_out, m_pc);
        chk("pc_valid", {31'd0, pc_valid_out}, {31'd0, m_valid()});
        chk("pred_taken", {31'd0, pred_taken_out}, {31'd0, m_pred()});
        chk("fetch_index", {27'd0, fetch_index_out}, {27'd0, m_pc[IW-1:0]});
        chk("fetch_tag", {5'd0, fetch_tag_out}, {5'd0, m_pc[PC-1:IW]});
    endtask

    // Called right after a falling edge with inputs already driven
    task automatic cycle();
        #1 check_outputs();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic clear_inputs();
        pc_ready_in      = 1'b0;
        fetch_hit_in     = 1'b0;
        update_in        = 1'b0;
        update_index_in  = '0;
        update_taken_in  = 1'b0;
        update_target_in = '0;
        redirect_in      = 1'b0;
        redirect_pc_in   = '0;
        halt_in          = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_in    = 1'b1;
        redirect_pc_in = pc;
        cycle();
        redirect_in    = 1'b0;
    endtask

    task automatic train(input logic [IW-1:0] idx, input logic taken, input logic [31:0] tgt);
        update_in        = 1'b1;
        update_index_in  = idx;
        update_taken_in  = taken;
        update_target_in = tgt;
    endtask

    initial begin
        rst_n_in = 1'b0;
        clear_inputs();
        model_reset();

        // Reset and sequencing
        @(negedge clk_in);
        #1 check_outputs();
        @(negedge clk_in);
        rst_n_in    = 1'b1;
        pc_ready_in = 1'b1;
        cycle();
        cycle();
        cycle();
        #1 chk("seq_pc8", pc_out, 32'h8);

        // Backpressure
        pc_ready_in = 1'b0;
        repeat (3) cycle();
        pc_ready_in = 1'b1;
        cycle();
        #1 chk("bp_next", pc_out, 32'hC);

        // Training and predict
        pc_ready_in = 1'b0;
        train(5'h10, 1'b1, 32'h40);
        repeat (2) cycle();
        update_in = 1'b0;
        redirect_to(32'h10);
        fetch_hit_in = 1'b1;
        pc_ready_in  = 1'b1;
        #1 chk("pred_hit", {31'd0, pred_taken_out}, 32'd1);
        cycle();
        #1 chk("pred_target", pc_out, 32'h40);
        fetch_hit_in = 1'b0;
        redirect_to(32'h10);
        cycle();
        #1 chk("nohit_next", pc_out, 32'h14);

        // Saturation
        pc_ready_in  = 1'b0;
        redirect_to(32'h10);
        fetch_hit_in = 1'b1;
        train(5'h10, 1'b1, 32'h40);
        cycle();
        update_in = 1'b0;
        #1 chk("sat_taken", {31'd0, pred_taken_out}, 32'd1);
        train(5'h10, 1'b0, 32'h0);
        repeat (4) cycle();
        update_in = 1'b0;
        cycle();
        #1 chk("sat_not_taken", {31'd0, pred_taken_out}, 32'd0);

        // Collision: counter 00 -> 01, then a taken update during the fetch read
        train(5'h10, 1'b1, 32'h80);
        cycle();
        pc_ready_in = 1'b1;
        #1 chk("coll_old", {31'd0, pred_taken_out}, 32'd0);
        cycle();
        update_in = 1'b0;
        #1 chk("coll_pc", pc_out, 32'h14);
        redirect_to(32'h10);
        #1 chk("coll_new", {31'd0, pred_taken_out}, 32'd1);

        // Redirect priority over halt and backpressure
        pc_ready_in = 1'b0;
        halt_in     = 1'b1;
        redirect_to(32'h100);
        halt_in     = 1'b0;
        #1 chk("redir_pc", pc_out, 32'h100);
        chk("redir_valid", {31'd0, pc_valid_out}, 32'd1);

        // Halt hold and release
        fetch_hit_in = 1'b0;
        redirect_to(32'h20);
        halt_in = 1'b1;
        cycle();
        halt_in     = 1'b0;
        pc_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("halt_valid", {31'd0, pc_valid_out}, 32'd0);
            chk("halt_pc", pc_out, 32'h20);
            cycle();
        end
        redirect_to(32'h200);
        #1 chk("halt_release_pc", pc_out, 32'h200);
        chk("halt_release_valid", {31'd0, pc_valid_out}, 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            pc_ready_in      = ($urandom_range(0, 9) < 7);
            fetch_hit_in     = ($urandom_range(0, 9) < 7);
            update_in        = ($urandom_range(0, 9) < 4);
            update_index_in  = 5'h10 | 5'($urandom_range(0, 3));
            update_taken_in  = $urandom_range(0, 1) == 1;
            update_target_in = $urandom() & 32'hFFFF_FFFC;
            redirect_in      = ($urandom_range(0, 99) < 8);
            redirect_pc_in   = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                           : ($urandom() & 32'h0000_007C);
            halt_in          = ($urandom_range(0, 99) < 5);
            cycle();
        end
        clear_inputs();

        // Mid-run asynchronous reset clears the table
        train(5'h10, 1'b1, 32'h40);
        repeat (2) cycle();
        update_in    = 1'b0;
        redirect_to(32'h30);
        fetch_hit_in = 1'b1;
        #2 rst_n_in  = 1'b0;
        #1 chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'd0, pc_valid_out}, 32'd0);
        chk("rst_pred", {31'd0, pred_taken_out}, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cycle();
        redirect_to(32'h10);
        #1 chk("rst_cnt_init", {31'd0, pred_taken_out}, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator for the RISC-V pipeline, directly upstream of the branch history table. It holds the fetch PC and drives the BHT fetch lookup index/tag. It combines the BHT hit with an internal 2-bit-counter/target table to predict the next PC with zero bubbles. It accepts mispredict redirects and predictor training from EX/MEM, and presents the PC to instruction fetch over a valid/ready handshake.

## Interface
- `TAG`, default 27: tag width, matches the BHT.
- `PC`, default 32: PC width; index width `IW = PC-TAG`.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk_in`, in, 1: clock, single clock domain.
- `rst_n_in`, in, 1: reset, asynchronous, active-low.
- `pc_valid_out`, out, 1: `pc_out` holds a fetch request.
- `pc_ready_in`, in, 1: fetch consumer accepts `pc_out` this cycle.
- `pc_out`, out, PC: current fetch PC.
- `pred_taken_out`, out, 1: prediction used for `pc_out`; travels down the pipe for mispredict check.
- `fetch_index_out`, out, IW: `pc_out[IW-1:0]`, to BHT.
- `fetch_tag_out`, out, TAG: `pc_out[PC-1:IW]`, to BHT.
- `fetch_hit_in`, in, 1: BHT hit for the current index/tag, combinational.
- `update_in`, in, 1: EX/MEM resolved a branch; train the table.
- `update_index_in`, in, IW: index of the resolved branch.
- `update_taken_in`, in, 1: resolved direction.
- `update_target_in`, in, PC: resolved taken target.
- `redirect_in`, in, 1: mispredict/exception; restart at `redirect_pc_in`.
- `redirect_pc_in`, in, PC: restart address.
- `halt_in`, in, 1: stop fetching (WFI/ebreak) until the next redirect.

## Operation
- FSM states: BOOT, RUN, HALT.
  - Reset enters BOOT.
  - BOOT→RUN after one cycle.
  - RUN→HALT on `halt_in` when `redirect_in` is 0.
  - HALT→RUN only on `redirect_in`.
  - `redirect_in` in any state except reset → RUN.
- `pc_valid_out` = 1 only in RUN.
- Table: 2**IW entries, each a 2-bit counter plus a PC-bit target.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Prediction: `pred_taken_out = pc_valid_out & fetch_hit_in & cnt[fetch_index_out][1]`.
  - Predicted next PC = `tgt[index]` if `pred_taken_out`, else `pc_out + 4`. The +4 wraps modulo 2**PC.
- PC register update, priority high→low:
  - `redirect_in`: load `redirect_pc_in`. Ignores ready and halt.
  - HALT or BOOT: hold.
  - `pc_valid_out & pc_ready_in`: load the predicted next PC.
  - Otherwise hold. `pc_out` and `pred_taken_out` stay stable while valid and not ready.
- Training on `update_in`:
  - Taken: counter saturating +1 (11 stays 11) and target written with `update_target_in`.
  - Not taken: counter saturating −1 (00 stays 00), target unchanged.
- Training is independent of FSM state and handshake, and is applied even in HALT.

## Timing
- Async reset, effective immediately:
  - `pc_out = RESET_PC`, `pc_valid_out = 0`, `pred_taken_out = 0`.
  - All counters = 01, all targets = 0.
  - State = BOOT.
- First valid fetch is on the 2nd rising edge after reset deassertion (one BOOT cycle).
- Prediction path is combinational within the cycle. The next PC is registered, so a predicted-taken branch costs 0 bubbles.
- Redirect latency: `pc_out = redirect_pc_in` with `pc_valid_out = 1` on the cycle after `redirect_in` is sampled.
- Training is written on the rising edge. Same-cycle update and fetch read of the same index: the read sees the pre-update value, and the new value is visible the next cycle.
- `halt_in` sampled high with `redirect_in` low: `pc_valid_out = 0` next cycle, PC held.
- `redirect_in` and `halt_in` together: redirect wins, state goes to RUN.
- Reset asserted mid-operation: outputs return to reset values asynchronously, and the table is reinitialised.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {BOOT, RUN, HALT}.
  - Counter constants `SNT=2'b00`, `WNT=2'b01`, `WT=2'b10`, `ST=2'b11`.
  - Counter reset constant `CNT_INIT = WNT`.
- One sub-module, `pht_table`: counter/target arrays with async reset, a combinational read port, and a saturating-update write port.
- Top level: FSM, PC register, next-PC mux.

## Test plan
- **Reset and sequencing:** release reset with ready=1, no hits.
  - First cycle after release: `pc_valid_out=0`, `pc_out=0x0`.
  - Then `pc_out` = 0x0, 0x4, 0x8 on consecutive cycles.
- **Backpressure:** `pc_ready_in=0` for 3 cycles at `pc_out=0x8`.
  - `pc_out` holds 0x8 with valid=1.
  - After ready=1, next `pc_out=0xC`.
- **Training and predict:** two `update_in` pulses, index 0x10, taken, target 0x40.
  - Counter goes 01→10→11.
  - At `pc_out=0x10` with `fetch_hit_in=1`: `pred_taken_out=1`, next `pc_out=0x40`.
  - Same PC with `fetch_hit_in=0`: next `pc_out=0x14`.
- **Saturation and collision:**
  - Third taken update: counter stays 11.
  - Four not-taken updates: counter reaches 00 and stays 00.
  - Update in the same cycle as the fetch read of index 0x10: the old prediction is used that cycle and the new one the next cycle.
- **Redirect priority:** `pc_ready_in=0`, `halt_in=1`, `redirect_in=1` with `redirect_pc_in=0x100`.
  - Next cycle: `pc_out=0x100`, `pc_valid_out=1`, state RUN.
- **Halt and mid-run reset:**
  - `halt_in` at `pc_out=0x20`: valid=0 and PC held for 5 cycles.
  - Redirect to 0x200: valid=1 with `pc_out=0x200`.
  - Then assert `rst_n_in` low mid-cycle: `pc_out=0x0` and valid=0 immediately, and a trained index reads counter 01.
